// File: rtl/btb_update_queue_pkg.sv
// Shared constants and helpers for the BTB update queue.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package btb_update_queue_pkg;

  localparam int ADDR_LEN   = 32;
  localparam int BTBQ_DEPTH = 4;
  localparam int BTBQ_PTR   = 2;

  // 8-bit counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/btb_update_queue_if.sv
// Branch-result / BTB-write bus of the BTB update queue.
// Latency: n/a (wires only).
// Backpressure: none; the branch side is never stalled.
interface btb_update_queue_if import btb_update_queue_pkg::*; #(
  parameter int ADDR_W = ADDR_LEN,
  parameter int PTR_W  = BTBQ_PTR
);

  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_src;
  logic [ADDR_W-1:0] br_dst;
  logic              flush;
  logic              hold;
  logic              we;
  logic [ADDR_W-1:0] jmpsrc;
  logic [ADDR_W-1:0] jmpdst;
  logic [PTR_W:0]    count;
  logic [7:0]        drop_cnt;

  modport master (
    output br_valid, br_taken, br_src, br_dst, flush, hold,
    input  we, jmpsrc, jmpdst, count, drop_cnt
  );

  modport slave (
    input  br_valid, br_taken, br_src, br_dst, flush, hold,
    output we, jmpsrc, jmpdst, count, drop_cnt
  );

endinterface

// File: rtl/btbq_fifo.sv
// Generic DEPTH x W storage ring with head/tail/count and in-place rewrite of the youngest entry.
// Latency: data written on an edge is readable from head/tail-1 right after that edge.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
module btbq_fifo import btb_update_queue_pkg::*; #(
  parameter int W     = 2 * ADDR_LEN,
  parameter int KEY_W = ADDR_LEN,
  parameter int DEPTH = BTBQ_DEPTH,
  parameter int PTR_W = BTBQ_PTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             wr_last,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head_dat,
  output logic [KEY_W-1:0] last_key,
  output logic [PTR_W:0]   count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W:0]   cnt;

  assign last_ptr = tail - PTR_W'(1);
  assign head_dat = mem[head];
  assign last_key = mem[last_ptr][W-1 -: KEY_W];
  assign count    = cnt;

  // Entry storage: append at tail, or rewrite the youngest entry in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push)    mem[tail]     <= din;
      if (wr_last) mem[last_ptr] <= din;
    end
  end

  // Pointers and occupancy; a clear drops everything older than this cycle's push.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clr) begin
      head <= tail;
      tail <= tail + PTR_W'(push);
      cnt  <= (PTR_W+1)'(push);
    end else begin
      if (pop)  head <= head + PTR_W'(1);
      if (push) tail <= tail + PTR_W'(1);
      cnt <= cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

endmodule

// File: rtl/btb_update_queue.sv
// Queues taken-branch outcomes and drains one per cycle into the BTB write port, coalescing repeats.
// Latency: update accepted into an empty, un-held queue appears on we/jmpsrc/jmpdst the next cycle.
// Backpressure: never stalls the branch unit; overflow is dropped and counted in drop_cnt.
module btb_update_queue import btb_update_queue_pkg::*; #(
  parameter int ADDR_W = ADDR_LEN,
  parameter int DEPTH  = BTBQ_DEPTH,
  parameter int PTR_W  = BTBQ_PTR
) (
  input logic               clk,
  input logic               reset,
  btb_update_queue_if.slave bus
);

  logic [2*ADDR_W-1:0] head_dat;
  logic [ADDR_W-1:0]   last_src;
  logic [PTR_W:0]      count;

  logic accept, empty, full;
  logic pop, bypass, coalesce, push, drop;

  logic              we_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        drop_q;

  assign accept = bus.br_valid & bus.br_taken;
  assign empty  = (count == '0);
  assign full   = (count == (PTR_W+1)'(DEPTH));

  // Oldest queued entry leaves unless held or flushed.
  assign pop    = ~empty & ~bus.hold & ~bus.flush;
  // With nothing queued, a new update goes straight to the BTB instead of taking a slot.
  assign bypass = accept & empty & ~bus.hold & ~bus.flush;
  // Same-PC repeat refreshes the youngest entry, unless that entry is the one leaving now.
  assign coalesce = accept & ~bus.flush & ~empty & (last_src == bus.br_src)
                  & ~(pop & (count == (PTR_W+1)'(1)));
  // A flush empties the ring, so a flushing update always finds room.
  assign push = accept & ~bypass & ~coalesce & (bus.flush | ~full | pop);
  assign drop = accept & ~bypass & ~coalesce & ~push;

  btbq_fifo #(
    .W     (2 * ADDR_W),
    .KEY_W (ADDR_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.flush),
    .push     (push),
    .pop      (pop),
    .wr_last  (coalesce),
    .din      ({bus.br_src, bus.br_dst}),
    .head_dat (head_dat),
    .last_key (last_src),
    .count    (count)
  );

  // BTB write port: strobe every issue cycle, data held steady while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q  <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
    end else begin
      we_q <= pop | bypass;
      if (pop) begin
        {src_q, dst_q} <= head_dat;
      end else if (bypass) begin
        src_q <= bus.br_src;
        dst_q <= bus.br_dst;
      end
    end
  end

  // Saturating tally of updates lost to overflow.
  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else if (drop) drop_q <= sat_inc8(drop_q);
  end

  assign bus.we       = we_q;
  assign bus.jmpsrc   = src_q;
  assign bus.jmpdst   = dst_q;
  assign bus.count    = count;
  assign bus.drop_cnt = drop_q;

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers resolved taken-branch outcomes from the branch execution unit and drains them, one per cycle, into the branch target buffer's write port (`we`/`jmpsrc`/`jmpdst`). It decouples branch resolution from BTB updates, coalesces back-to-back updates to the same source PC, and never back-pressures the branch unit. Instantiated between the branch ALU result bus and the `btb` instance in the fetch stage.

## Interface
- `ADDR_W`, default `ADDR_LEN` (32): PC width.
- `DEPTH`, default 4: queue entries, power of two.
- `PTR_W`, default 2: log2(DEPTH).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `br_valid` in 1: resolved branch/jump result valid this cycle.
- `br_taken` in 1: branch resolved taken; not-taken results are ignored.
- `br_src` in ADDR_W: PC of the branch.
- `br_dst` in ADDR_W: resolved target.
- `flush` in 1: discard all queued, not-yet-issued entries.
- `hold` in 1: inhibit issue this cycle.
- `we` out 1: BTB write strobe, registered.
- `jmpsrc` out ADDR_W: BTB write source PC, registered.
- `jmpdst` out ADDR_W: BTB write target, registered.
- `count` out PTR_W+1: current occupancy, 0..DEPTH.
- `drop_cnt` out 8: saturating count of dropped updates.

## Operation
- Accept condition: `br_valid & br_taken`.
- Coalesce: if accepted, count>0, and `br_src` equals the src of the youngest entry (tail-1), and that entry is not being issued this cycle, overwrite its dst; no new slot.
- Otherwise enqueue at tail if not full, or if full and an issue occurs this cycle.
- Otherwise drop; `drop_cnt` increments, saturating at 255.
- Issue: when count>0 and `hold`=0, pop head; next cycle `we`=1, `jmpsrc`/`jmpdst`=popped entry. Else next cycle `we`=0, and `jmpsrc`/`jmpdst` hold their last values.
- Flush: all entries present at the start of the cycle are discarded and no issue occurs that cycle. A same-cycle accepted update is still enqueued as the sole entry, because the flush-causing branch's outcome is valid. Coalescing is suppressed. `drop_cnt` is unaffected.
- Flush and hold together: same as flush.
- Pointers are PTR_W bits and wrap modulo DEPTH. Occupancy is tracked separately so full (count=DEPTH) and empty (count=0) are unambiguous.
- No FSM beyond the FIFO; the state is head/tail pointers, count, entries, and output registers.

## Timing
- Reset: `we`=0, `jmpsrc`=0, `jmpdst`=0, `count`=0, `drop_cnt`=0; pointers 0; entries invalid.
- Reset mid-operation discards all entries. No `we` is asserted the cycle after reset.
- Latency with an empty queue and no hold: accepted in cycle N, `we`=1 in cycle N+1.
- Throughput: one BTB write per cycle.
- `count` reflects the state after the previous edge, i.e. the registered value.
- An entry coalesced in cycle N issues with the updated dst.
- The BTB consumes writes on its own edge. This block guarantees only that `we`/`jmpsrc`/`jmpdst` are stable for the full cycle.

## Structure
- `ADDR_LEN` comes from the shared constants header.
- Add `BTBQ_DEPTH` and `BTBQ_PTR` to the same header.
- One sub-module: `btbq_fifo`, a generic DEPTH x (2·ADDR_W) storage array with head/tail/count and in-place tail-1 write. The top level holds the coalesce/drop/issue logic and output registers.

## Test plan
- Basic: reset; in cycle 1 send valid, taken, src=0x100, dst=0x200 -> cycle 2 has `we`=1, `jmpsrc`=0x100, `jmpdst`=0x200; cycle 3 has `we`=0 and `count`=0.
- Not-taken filter and coalesce: hold=1; send src=0x40/dst=0x80 (taken), src=0x44 (not taken), then src=0x40/dst=0x90 -> `count`=1. Release hold -> one write with 0x40→0x90.
- Full/drop/wrap: hold=1; send 5 distinct taken updates -> `count`=4, `drop_cnt`=1. Release hold -> 4 writes in order in consecutive cycles. Repeat 3 times to exercise pointer wrap and check ordering.
- Full with simultaneous issue: with `count`=4, hold=0, send a new update -> accepted, `drop_cnt` unchanged, 5 writes total.
- Flush: queue 3 entries under hold; assert flush while sending src=0x300/dst=0x400 -> next `count`=1; the only subsequent write is 0x300→0x400.
- Reset mid-drain: with 3 queued and `we` active, assert reset -> next cycle `we`=0 and `count`=0, and no further writes occur.
